// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: closes the PC loop, issues imem requests and buffers in-order responses for decode.
// Redirects flush the queue and count off stale in-flight responses before fetching resumes.
module instr_fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] PC,
  output logic [N-1:0] PC_next,
  output logic         imem_req_valid,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  input  logic         redirect,
  input  logic [N-1:0] redirect_target,
  output logic         dec_valid,
  output logic [N-1:0] dec_instr,
  output logic [N-1:0] dec_pc,
  input  logic         dec_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [N-1:0]     pc_q [DEPTH];
  logic [N-1:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d, infl_q, infl_d, drop_q, drop_d, stale;
  logic             accept, keep, pop;
  assign imem_req_valid = !rst && !redirect && count_q < CW'(DEPTH) && drop_q == '0;
  assign imem_req_addr  = PC;
  assign accept         = imem_req_valid && imem_req_ready;
  // A response is kept only when it matches an outstanding, non-stale request
  assign keep           = imem_rsp_valid && !redirect && drop_q == '0 && infl_q != '0;
  assign dec_valid      = filled_q[rd_q] && !redirect;
  assign pop            = dec_valid && dec_ready;
  assign dec_instr      = instr_q[rd_q];
  assign dec_pc         = pc_q[rd_q];
  assign PC_next        = redirect ? {redirect_target[N-1:2], 2'b00} : accept ? PC + N'(4) : PC;
  assign stale          = drop_q + infl_q;
  assign alloc_d        = redirect ? '0 : alloc_q + AW'(accept);
  assign fill_d         = redirect ? '0 : fill_q + AW'(keep);
  assign rd_d           = redirect ? '0 : rd_q + AW'(pop);
  assign count_d        = redirect ? '0 : count_q + CW'(accept) - CW'(pop);
  assign infl_d         = redirect ? '0 : infl_q + CW'(accept) - CW'(keep);
  // The response arriving in the redirect cycle itself is already one of the stale ones
  assign drop_d         = redirect ? stale - CW'(imem_rsp_valid && stale != '0)
                                   : drop_q - CW'(imem_rsp_valid && drop_q != '0);
  always_comb begin
    filled_d = filled_q;
    if (accept) filled_d[alloc_q] = 1'b0;
    if (keep) filled_d[fill_q] = 1'b1;
    if (pop) filled_d[rd_q] = 1'b0;
    if (redirect) filled_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      drop_q   <= '0;
    end else begin
      filled_q <= filled_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) pc_q[alloc_q] <= PC;
    if (keep) instr_q[fill_q] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench with a PC register and an in-order fixed-latency instruction memory.
module tb_instr_fetch_queue;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] PC = '0, PC_next;
  logic        imem_req_valid, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;
  int checks = 0, failures = 0, cyc = 0, lat = 1, n_acc = 0, base = 0;
  typedef struct {logic [31:0] a; int due;} req_t;
  req_t mq[$];

  instr_fetch_queue #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PC(PC), .PC_next(PC_next),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_target(redirect_target),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) PC <= '0;
    else PC <= PC_next;

  // Memory: record accepts mid-cycle, return each response lat cycles later, one per cycle, in order
  initial forever begin
    @(negedge clk);
    #2;
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].a ^ 32'hA5A5_0000;
      void'(mq.pop_front());
    end
  end

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy, input int l);
    @(negedge clk);
    rst = 1'b1;
    dec_ready = rdy;
    lat = l;
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_next", PC_next, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_next", PC_next, 32'd0);
    // Reset release and 1-cycle-latency stream
    @(negedge clk);
    rst = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'd0);
    chk("first_pc_next", PC_next, 32'd4);
    @(negedge clk); #1;
    chk("stream_lat", 32'(dec_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("stream_valid", 32'(dec_valid), 32'd1);
      chk("stream_pc", dec_pc, 32'(4 * i));
      chk("stream_instr", dec_instr, ins(32'(4 * i)));
    end
    // Full queue with decode stalled
    do_reset(1'b0, 1);
    rst = 1'b0;
    #1;
    base = n_acc;
    repeat (4) @(negedge clk);
    #1;
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_pc_next", PC_next, 32'h10);
    repeat (2) @(negedge clk);
    #1;
    chk("full_pc_hold", PC, 32'h10);
    chk("full_accepts", 32'(n_acc - base), 32'd4);
    chk("full_dec_valid", 32'(dec_valid), 32'd1);
    chk("full_dec_pc", dec_pc, 32'd0);
    @(negedge clk);
    dec_ready = 1'b1;
    #1;
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_dec_pc0", dec_pc, 32'd0);
    @(negedge clk); #1;
    chk("bp_req_valid_after_pop", 32'(imem_req_valid), 32'd1);
    chk("bp_req_addr", imem_req_addr, 32'h10);
    chk("bp_dec_pc1", dec_pc, 32'd4);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_dec_valid", 32'(dec_valid), 32'd1);
      chk("bp_dec_pc", dec_pc, 32'(4 * i));
      chk("bp_dec_instr", dec_instr, ins(32'(4 * i)));
    end
    // Redirect with two responses in flight, latency 3
    do_reset(1'b1, 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    redirect = 1'b1;
    redirect_target = 32'h203;
    #1;
    chk("redir_pc_next", PC_next, 32'h200);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    chk("redir_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drop_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk); #1;
    chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drop_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk); #1;
    chk("redir_req_resume", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("redir_no_stale", 32'(dec_valid), 32'd0);
    end
    @(negedge clk); #1;
    chk("redir_first_valid", 32'(dec_valid), 32'd1);
    chk("redir_first_pc", dec_pc, 32'h200);
    chk("redir_first_instr", dec_instr, ins(32'h200));
    // Redirect in the same cycle as a response, three in flight
    do_reset(1'b1, 3);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_target = 32'h300;
    #1;
    chk("coinc_pc_next", PC_next, 32'h300);
    chk("coinc_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk); #1;
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd0);
    chk("coinc_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk); #1;
    chk("coinc_req_resume", 32'(imem_req_valid), 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("coinc_no_stale", 32'(dec_valid), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("coinc_dec_valid", 32'(dec_valid), 32'd1);
      chk("coinc_dec_pc", dec_pc, 32'h300 + 32'(4 * i));
      chk("coinc_dec_instr", dec_instr, ins(32'h300 + 32'(4 * i)));
    end
    // Address wrap-around
    do_reset(1'b1, 1);
    rst = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    #1;
    chk("wrap_pc_next", PC_next, 32'hFFFF_FFF8);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    chk("wrap_pc_next1", PC_next, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_pc_next2", PC_next, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("wrap_dec_valid", 32'(dec_valid), 32'd1);
      chk("wrap_dec_pc", dec_pc, 32'hFFFF_FFF8 + 32'(4 * i));
    end
    // Reset with three filled entries and a late response pending
    do_reset(1'b0, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    lat = 4;
    #1;
    chk("mid_dec_valid", 32'(dec_valid), 32'd1);
    chk("mid_dec_pc", dec_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    lat = 1;
    #1;
    chk("mid_rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mid_rel_dec_valid", 32'(dec_valid), 32'd0);
    @(negedge clk); #1;
    chk("mid_late_dec_valid", 32'(dec_valid), 32'd0);
    chk("mid_late_pc_next", PC_next, 32'd0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    chk("mid_stray_ignored", 32'(dec_valid), 32'd0);
    chk("mid_restart_addr", imem_req_addr, 32'd0);
    chk("mid_restart_pc_next", PC_next, 32'd4);
    @(negedge clk); #1;
    chk("mid_restart_lat", 32'(dec_valid), 32'd0);
    @(negedge clk); #1;
    chk("mid_restart_valid", 32'(dec_valid), 32'd1);
    chk("mid_restart_pc", dec_pc, 32'd0);
    chk("mid_restart_instr", dec_instr, ins(32'd0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch stage that sits directly downstream of the program counter register and closes its loop. Each cycle it takes the registered `PC`, issues an instruction-memory request at that address, and produces `PC_next` (advance, hold or redirect). Returned instructions are buffered in order in a small queue, together with their PCs, and handed to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard stale responses.

## Interface
- `N`, 32: address and instruction width.
- `DEPTH`, 4: queue entries. Must be a power of 2, at least 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `PC`  in  N  current fetch address from the program counter register.
- `PC_next`  out  N  combinational next fetch address, fed back to the program counter.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  N  request address; always equals `PC`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response valid. Responses arrive in order, at least 1 cycle after acceptance, and cannot be back-pressured.
- `imem_rsp_data`  in  N  instruction word.
- `redirect`  in  1  flush request from execute.
- `redirect_target`  in  N  new fetch address; bits [1:0] are ignored and treated as 0.
- `dec_valid`  out  1  head entry is available to decode.
- `dec_instr`  out  N  head instruction.
- `dec_pc`  out  N  address of the head instruction.
- `dec_ready`  in  1  decode consumes the head entry.

## Operation
- **Queue structure.** Circular queue of `DEPTH` entries, each holding {pc, instr, filled}. Three pointers:
  - alloc pointer: allocates an entry on request accept (`imem_req_valid & imem_req_ready`) and writes pc = `PC`, filled = 0.
  - fill pointer: each kept response writes `imem_rsp_data` into the oldest unfilled entry and sets filled = 1.
  - read pointer: pops the head when `dec_valid & dec_ready`.
- **Occupancy.** `count` = allocated entries (in-flight plus filled), range 0..`DEPTH`. It is updated for simultaneous accept and pop in the same cycle.
- **Request valid.** `imem_req_valid = !rst & !redirect & (count < DEPTH) & (drop_cnt == 0)`. Every accepted request therefore already owns a slot, so responses never overflow.
- **PC_next priority:**
  - `redirect` → `{redirect_target[N-1:2], 2'b00}`;
  - else request accepted → `PC + 4`, modulo 2^N (0xFFFFFFFC → 0x00000000);
  - else → `PC` (hold).
- **Decode output.**
  - `dec_valid = head.filled & !redirect`.
  - `dec_instr` and `dec_pc` come from the head entry.
  - No bypass: a response is visible on `dec_*` the cycle after it arrives.
- **Redirect.**
  - All entries are invalidated and all pointers and `count` are cleared at the next edge.
  - `drop_cnt` is loaded with the in-flight (allocated, unfilled) count, minus 1 if `imem_rsp_valid` is high in the redirect cycle. That same-cycle response is discarded.
  - While `drop_cnt > 0`, each response decrements `drop_cnt` and is discarded, and no requests issue.
  - A pop attempted in the redirect cycle has no effect.
- **Stray responses.** A response arriving with no outstanding request and `drop_cnt == 0` is ignored.
- **Simultaneous events.** Accept, fill and pop in the same cycle are all legal and must all take effect. A redirect overrides all three.

## Timing
- **Reset (async, while asserted and after):**
  - pointers, `count` and `drop_cnt` = 0; all filled bits = 0;
  - `dec_valid` = 0, `imem_req_valid` = 0;
  - `PC_next = PC` (0 from the program counter).
- **First request.** Issues in the first cycle after `rst` deasserts.
- **Latency.**
  - Request accepted at cycle t → response at t+k (k ≥ 1) → `dec_valid` at t+k+1.
  - Best-case steady state with k = 1 and `dec_ready` held high: 1 instruction per cycle.
- **Redirect.**
  - Cycle r: `PC_next` = target and `imem_req_valid` = 0.
  - Cycle r+1: request at target, provided `drop_cnt == 0`; otherwise it waits until the last stale response has been dropped.
- **Reset mid-operation.** All state clears immediately. Responses arriving after release with nothing outstanding are ignored.
- **Full.** With `count == DEPTH`: `imem_req_valid` = 0 and `PC_next = PC`. A pop frees a slot, so a request can issue the next cycle.

## Test plan
- **Reset and stream.** Release reset; memory returns `mem[a] = a ^ 0xA5A5_0000` with 1-cycle latency; `dec_ready` = 1.
  - Required: `dec_pc` = 0, 4, 8, … on consecutive cycles starting 2 cycles after the first accept, with matching `dec_instr`.
- **Full and back-pressure.** Hold `dec_ready` = 0.
  - Required: exactly `DEPTH` (4) requests accepted; `PC` holds at 0x10.
  - Then raise `dec_ready`: entries pop in order 0x0..0xC, and a request at 0x10 issues the cycle after the first pop.
- **Redirect with in-flight responses.** Memory latency 3; two requests outstanding; assert `redirect` with target 0x203.
  - Required: `PC_next` = 0x200; the 2 stale responses are dropped and never appear on `dec_*`.
  - The first `dec_pc` after the redirect is 0x200.
- **Redirect coincident with a response.**
  - Required: that response is discarded; `drop_cnt` = in-flight − 1; no queue corruption.
- **Wrap-around.** Reset, then redirect to 0xFFFFFFF8.
  - Required: `dec_pc` sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset mid-stream.** Assert `rst` while 3 entries are full.
  - Required: `dec_valid` drops immediately; after release, fetch restarts at 0.
  - Late responses arriving after release are ignored.
